red_pitaya_gpio: RTL
====================

RED_PITAYA_GPIO -- requirements
Module: red_pitaya_gpio

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the expansion pin count (legal 1..32).
REQ-002 The block SHALL have parameter DBW, default 16, giving the debounce counter width (legal 1..32).
REQ-003 The block SHALL have parameter DEB_RST, default 0, giving the DEB_LEN register reset value.
REQ-004 clk_i  in  1  system clock; every register is clocked on its rising edge.
REQ-005 rstn_i  in  1  reset; asynchronous assertion, active low.
REQ-006 exp_dat_i  in  DW  expansion pin inputs, asynchronous to clk_i.
REQ-007 exp_dat_o  out  DW  expansion pin output data.
REQ-008 exp_dir_o  out  DW  per-pin output enable; 1 = output.
REQ-009 irq_o  out  1  interrupt; level high while any status bit is set.
REQ-010 sys_addr  in  32  bus address; only bits [19:0] are decoded.
REQ-011 sys_wdata  in  32  bus write data.
REQ-012 sys_wen / sys_ren  in  1 each  bus write / read strobes, one cycle each.
REQ-013 sys_rdata  out  32  bus read data.
REQ-014 sys_err  out  1  bus error; always 0.
REQ-015 sys_ack  out  1  bus acknowledge.

Function
REQ-016 Register map SHALL be:
- 0x00 ID (RO) = {24'h000002, DW[7:0]}
- 0x04 DIR (RW)
- 0x08 DOUT (RW)
- 0x0C DIN (RO) = debounced inputs
- 0x10 SET (WO): DOUT |= wdata
- 0x14 CLR (WO): DOUT &= ~wdata
- 0x18 RISE_EN (RW)
- 0x1C FALL_EN (RW)
- 0x20 STATUS (R/W1C)
- 0x24 DEB_LEN (RW, DBW bits)
REQ-017 Register fields narrower than 32 bits SHALL read 0 in their unused upper bits, and write data in those bits SHALL be ignored.
REQ-018 sys_ack SHALL equal (sys_wen|sys_ren) delayed one clock, for every address, including unmapped addresses.
REQ-019 sys_rdata SHALL be registered, valid with sys_ack, and 0 for unmapped addresses, SET and CLR.
REQ-020 Writes to RO or unmapped addresses SHALL have no effect.
REQ-021 exp_dat_o SHALL equal DOUT, and exp_dir_o SHALL equal DIR.
REQ-022 Each exp_dat_i bit SHALL pass through a 2-flop synchronizer: s1 <= pin, then s2 <= s1.
REQ-023 Debounce, per bit, using counter cnt[DBW-1:0] and state deb:
- if s2 == deb: cnt <= 0
- else if cnt == DEB_LEN: deb <= s2, cnt <= 0
- else: cnt <= cnt+1
REQ-024 Resulting latency: a pin change sampled at edge k SHALL appear in DIN at edge k+2+DEB_LEN; DEB_LEN = 0 gives latency k+2.
REQ-025 A glitch on s2 shorter than DEB_LEN+1 cycles SHALL leave deb unchanged and reset cnt to 0.
REQ-026 On the edge where deb goes 0->1 with RISE_EN[i] = 1, or 1->0 with FALL_EN[i] = 1, STATUS[i] SHALL be set.
REQ-027 When a W1C write and a new event hit the same STATUS bit in the same cycle, the set SHALL win.
REQ-028 Clearing RISE_EN or FALL_EN SHALL NOT clear STATUS bits that are already set.
REQ-029 irq_o SHALL be the combinational OR of STATUS.
REQ-030 A DEB_LEN write SHALL take effect on the next cycle; counters already above the new DEB_LEN SHALL count to wrap and then continue normally, with no lockup.
REQ-031 Any bit with DIR = 1 SHALL still be sampled and debounced.

Reset
REQ-032 While rstn_i = 0, the following SHALL be 0: DIR, DOUT, RISE_EN, FALL_EN, STATUS, s1, s2, deb, cnt, sys_ack, sys_err, sys_rdata, irq_o, exp_dat_o and exp_dir_o.
REQ-033 While rstn_i = 0, DEB_LEN SHALL equal DEB_RST.
REQ-034 Reset asserted mid-debounce or mid-bus-cycle SHALL abort the operation; no ack SHALL be issued for a strobe that coincides with reset.

Verification
REQ-035 Bus: write 0xA5 to DIR, 0x3C to DOUT, then read 0x04, 0x08 and 0x00 -> reads return 0xA5, 0x3C and 0x00000208; exp_dir_o = 0xA5; each ack arrives 1 cycle after its strobe; a read of 0x40 returns 0 with ack.
REQ-036 SET/CLR: DOUT = 0x0F, write SET 0xF0, then CLR 0x03 -> DOUT = 0xFC; reads of 0x10 and 0x14 return 0.
REQ-037 Debounce: DEB_LEN = 4, pin0 rises at edge k -> DIN[0] = 1 at edge k+6; a 4-cycle pulse on pin1 -> DIN[1] stays 0.
REQ-038 IRQ: RISE_EN = 0x01, pin0 rises -> STATUS = 0x01 and irq_o = 1; W1C 0x01 -> irq_o = 0; a W1C issued in the same cycle as a new edge leaves STATUS[0] = 1.
REQ-039 Reset: rstn_i asserted mid-debounce with STATUS = 0xFF -> every output is 0 immediately and DEB_LEN = DEB_RST.

Source files
------------

// File: rtl/red_pitaya_gpio.sv
// -----------------------------------------------------------------------------
// red_pitaya_gpio
//
// Memory-mapped GPIO block for the expansion connector. Each pin has a
// direction bit and an output data bit. Every pin is also sampled through a
// two-flop synchronizer and a per-pin debouncer, whatever its direction.
// Debounced edges can raise sticky status bits that drive an interrupt.
//
// Ports
//   clk_i, rstn_i        system clock, asynchronous active-low reset
//   exp_dat_i [DW]       expansion pin inputs (asynchronous to clk_i)
//   exp_dat_o [DW]       expansion pin output data (DOUT)
//   exp_dir_o [DW]       per-pin output enable, 1 = output (DIR)
//   irq_o                high while any STATUS bit is set
//   sys_addr/sys_wdata   bus address (bits [19:0] decoded) / write data
//   sys_wen/sys_ren      single-cycle write / read strobes
//   sys_rdata            registered read data, valid with sys_ack
//   sys_err              bus error, tied low
//   sys_ack              strobe acknowledge, one cycle after the strobe
//
// Register map (byte offsets)
//   0x00 ID  0x04 DIR  0x08 DOUT  0x0C DIN  0x10 SET  0x14 CLR
//   0x18 RISE_EN  0x1C FALL_EN  0x20 STATUS (W1C)  0x24 DEB_LEN
// -----------------------------------------------------------------------------
module red_pitaya_gpio #(
    parameter int          DW      = 8,
    parameter int          DBW     = 16,
    parameter int unsigned DEB_RST = 0
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [DW-1:0] exp_dat_i,
    output logic [DW-1:0] exp_dat_o,
    output logic [DW-1:0] exp_dir_o,
    output logic          irq_o,
    input  logic [31:0]   sys_addr,
    input  logic [31:0]   sys_wdata,
    input  logic          sys_wen,
    input  logic          sys_ren,
    output logic [31:0]   sys_rdata,
    output logic          sys_err,
    output logic          sys_ack
);

    localparam logic [19:0] A_ID      = 20'h00000;
    localparam logic [19:0] A_DIR     = 20'h00004;
    localparam logic [19:0] A_DOUT    = 20'h00008;
    localparam logic [19:0] A_DIN     = 20'h0000C;
    localparam logic [19:0] A_SET     = 20'h00010;
    localparam logic [19:0] A_CLR     = 20'h00014;
    localparam logic [19:0] A_RISE_EN = 20'h00018;
    localparam logic [19:0] A_FALL_EN = 20'h0001C;
    localparam logic [19:0] A_STATUS  = 20'h00020;
    localparam logic [19:0] A_DEB_LEN = 20'h00024;

    // Control / status registers
    logic [DW-1:0]  dir_q,     dir_d;
    logic [DW-1:0]  dout_q,    dout_d;
    logic [DW-1:0]  rise_en_q, rise_en_d;
    logic [DW-1:0]  fall_en_q, fall_en_d;
    logic [DW-1:0]  status_q,  status_d;
    logic [DBW-1:0] deb_len_q, deb_len_d;

    // Input path: synchronizer, debounced state and per-pin counters
    logic [DW-1:0]           s1_q, s2_q;
    logic [DW-1:0]           deb_q, deb_d;
    logic [DW-1:0][DBW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]           edge_evt;

    // Bus response
    logic        ack_q,   ack_d;
    logic [31:0] rdata_q, rdata_d;

    logic [19:0]    addr;
    logic [DW-1:0]  wdat;
    logic           unused_bits;

    assign addr = sys_addr[19:0];
    assign wdat = sys_wdata[DW-1:0];

    // Only the low address bits and low data bits are meaningful.
    assign unused_bits = ^{sys_addr[31:20], sys_wdata};

    // Debounce: the counter runs while the synchronized input disagrees with
    // the debounced state and commits it once the count reaches DEB_LEN. A
    // counter already past a freshly lowered DEB_LEN simply wraps through zero
    // and meets the new limit on the way back up.
    always_comb begin
        deb_d    = deb_q;
        cnt_d    = cnt_q;
        edge_evt = '0;
        for (int i = 0; i < DW; i++) begin
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == deb_len_q) begin
                deb_d[i] = s2_q[i];
                cnt_d[i] = '0;
                edge_evt[i] = s2_q[i] ? rise_en_q[i] : fall_en_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + DBW'(1);
            end
        end
    end

    // Register writes. A new edge event is ORed in after the W1C mask so a
    // clear and a set landing in the same cycle leave the bit set.
    always_comb begin
        dir_d     = dir_q;
        dout_d    = dout_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        deb_len_d = deb_len_q;
        status_d  = status_q;
        if (sys_wen) begin
            case (addr)
                A_DIR:     dir_d     = wdat;
                A_DOUT:    dout_d    = wdat;
                A_SET:     dout_d    = dout_q | wdat;
                A_CLR:     dout_d    = dout_q & ~wdat;
                A_RISE_EN: rise_en_d = wdat;
                A_FALL_EN: fall_en_d = wdat;
                A_STATUS:  status_d  = status_q & ~wdat;
                A_DEB_LEN: deb_len_d = sys_wdata[DBW-1:0];
                default:   ;
            endcase
        end
        status_d = status_d | edge_evt;
    end

    // Read mux and acknowledge
    always_comb begin
        ack_d   = sys_wen | sys_ren;
        rdata_d = '0;
        if (sys_ren) begin
            case (addr)
                A_ID:      rdata_d = {24'h000002, 8'(DW)};
                A_DIR:     rdata_d = 32'(dir_q);
                A_DOUT:    rdata_d = 32'(dout_q);
                A_DIN:     rdata_d = 32'(deb_q);
                A_RISE_EN: rdata_d = 32'(rise_en_q);
                A_FALL_EN: rdata_d = 32'(fall_en_q);
                A_STATUS:  rdata_d = 32'(status_q);
                A_DEB_LEN: rdata_d = 32'(deb_len_q);
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dir_q     <= '0;
            dout_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            deb_len_q <= DBW'(DEB_RST);
            s1_q      <= '0;
            s2_q      <= '0;
            deb_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            dir_q     <= dir_d;
            dout_q    <= dout_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            deb_len_q <= deb_len_d;
            s1_q      <= exp_dat_i;
            s2_q      <= s1_q;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign exp_dat_o = dout_q;
    assign exp_dir_o = dir_q;
    assign irq_o     = |status_q;
    assign sys_ack   = ack_q;
    assign sys_rdata = rdata_q;
    assign sys_err   = 1'b0;

endmodule
